edge_pipeline_sequencer: RTL and testbench
==========================================

Name: edge_pipeline_sequencer

Overview:
Parametrised row-sequencing controller for the edge-detection datapath. It walks an IMG_WIDTH x IMG_HEIGHT image row by row. For each row it reads from the source BRAM, starts convolution and waits for completion, then writes the result row to BRAM4. After the last row it runs NMS and then thresholding, each with a start/done handshake. It sits between the host/top-level start logic and the convolution, NMS and threshold units.

Parameters:
IMG_WIDTH, 8, pixels per row (>=2)
IMG_HEIGHT, 8, rows per image (>=1)
ADDR_WIDTH, 12, BRAM address width; must satisfy DST_BASE + IMG_WIDTH*IMG_HEIGHT <= 2**ADDR_WIDTH
SRC_BASE, 0, first source-pixel address
DST_BASE, 2048, first BRAM4 address

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  synchronous, active-low reset
enable  input  1  advance enable; low = freeze
start  input  1  begin a frame; sampled only in IDLE
abort  input  1  synchronous abort to IDLE
conv_done  input  1  convolution finished the current row
nsm_done  input  1  NMS pass finished
thr_done  input  1  thresholding finished
bram_addr  output  ADDR_WIDTH  read or write address
transfer_data  output  1  source read strobe
write_bram4  output  1  BRAM4 write strobe
start_convolution  output  1  one-cycle start pulse
start_nsm  output  1  one-cycle start pulse
start_thresholding  output  1  one-cycle start pulse
row_idx  output  clog2(IMG_HEIGHT)  current row
busy  output  1  high whenever state != IDLE
frame_done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low; all outputs and state are registered.
- Reset values: state=IDLE; row/col counters=0; all outputs 0.
- States: IDLE, READ_ROW, CONV_WAIT, WRITE_ROW, NSM_WAIT, THR_WAIT, DONE.
- IDLE: if start && enable, go to READ_ROW with row=0, col=0.
- READ_ROW:
  - transfer_data=1 for IMG_WIDTH enabled cycles.
  - bram_addr = SRC_BASE + row*IMG_WIDTH + col, with col counting 0..IMG_WIDTH-1.
  - After col=IMG_WIDTH-1, go to CONV_WAIT with col=0.
- CONV_WAIT:
  - start_convolution=1 in the first enabled cycle of the state only.
  - Stay until conv_done=1, then go to WRITE_ROW.
  - conv_done arriving in the same cycle as the start pulse counts.
- WRITE_ROW:
  - write_bram4=1 for IMG_WIDTH cycles.
  - bram_addr = DST_BASE + row*IMG_WIDTH + col.
  - At the end: if row==IMG_HEIGHT-1, go to NSM_WAIT; else row+1 and go to READ_ROW.
- NSM_WAIT: start_nsm pulses on entry; leave on nsm_done, go to THR_WAIT.
- THR_WAIT: start_thresholding pulses on entry; leave on thr_done, go to DONE.
- DONE: frame_done=1 for exactly one cycle, then go to IDLE.
- Address rules: bram_addr=0 whenever neither strobe is high. Address arithmetic is computed at ADDR_WIDTH bits; no wrap is permitted by the parameter constraint. An incremental address register is allowed instead of a multiplier.
- enable=0:
  - State and counters hold; all strobes and start pulses are forced 0.
  - A start pulse not yet issued is issued on the first enabled cycle.
  - *_done inputs are ignored while enable=0.
- abort: highest priority after reset. The next cycle is IDLE with counters 0 and all outputs 0; frame_done is not asserted.
- Simultaneous events:
  - start in a non-IDLE state is ignored.
  - Stray done inputs outside their wait state are ignored.
  - Reset mid-frame behaves like abort.
- Latency: start accepted at cycle 0 gives the first read address at cycle 1. With zero-latency done responses, a frame takes H*(2W+1)+3 cycles to the frame_done pulse, the +3 covering the NSM, THR and DONE states.

Decomposition:
- Package edge_pipeline_pkg holds:
  - the state_t enum (3-bit) for the seven states;
  - a function for clog2-based row_idx width;
  - the default SRC_BASE/DST_BASE constants.
- Sub-module row_addr_gen (col counter, row base register, address adder, last-column flag) is natural; the FSM stays in the top.

Test Plan:
- W=4, H=3, SRC_BASE=0, DST_BASE=2048; done inputs returned 2 cycles after each start -> read addresses 0..3, 4..7, 8..11; write addresses 2048..2051, 2052..2055, 2056..2059; start_convolution pulses exactly 3 times; one start_nsm and one start_thresholding; frame_done pulses once; busy drops the cycle after it.
- Same config, toggle enable low for 5 cycles mid-READ_ROW at col=2 -> transfer_data=0 during the freeze; resumes at address row_base+2; no address is skipped or repeated.
- Assert abort during CONV_WAIT of row 1 -> next cycle IDLE, all outputs 0, no frame_done; a fresh start then begins at address 0.
- Pulse conv_done during READ_ROW and nsm_done during CONV_WAIT -> both ignored; the sequence is unchanged.
- Drop reset_n low for 1 cycle during WRITE_ROW -> all outputs 0 on the following edge; state IDLE; row_idx=0.
- H=1, W=2, with done inputs tied high -> frame_done 8 cycles after start is accepted.

Source files
------------

// File: rtl/edge_pipeline_sequencer_pkg.sv
// edge_pipeline_pkg: shared state encoding, address defaults and width helper for the edge pipeline sequencer
package edge_pipeline_pkg;
    typedef enum logic [2:0] {IDLE, READ_ROW, CONV_WAIT, WRITE_ROW, NSM_WAIT, THR_WAIT, DONE} state_t;
    localparam int DEF_SRC_BASE = 0;
    localparam int DEF_DST_BASE = 2048;
    function automatic int row_w(input int h);
        return h > 1 ? $clog2(h) : 1;
    endfunction
endpackage

// File: rtl/edge_pipeline_sequencer_if.sv
// edge_pipeline_sequencer_if: control, handshake and BRAM strobe bundle between the sequencer and the datapath units
interface edge_pipeline_sequencer_if
    import edge_pipeline_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int ROW_W = row_w(8)
);
    logic enable, start, abort, conv_done, nsm_done, thr_done;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic transfer_data, write_bram4, start_convolution, start_nsm, start_thresholding, busy, frame_done;
    logic [ROW_W-1:0] row_idx;
    modport master (
        input  enable, start, abort, conv_done, nsm_done, thr_done,
        output bram_addr, transfer_data, write_bram4, start_convolution, start_nsm, start_thresholding,
               row_idx, busy, frame_done
    );
    modport slave (
        output enable, start, abort, conv_done, nsm_done, thr_done,
        input  bram_addr, transfer_data, write_bram4, start_convolution, start_nsm, start_thresholding,
               row_idx, busy, frame_done
    );
endinterface

// File: rtl/edge_pipeline_sequencer_row_addr_gen.sv
// row_addr_gen: column counter plus incrementally maintained row base, giving the in-image pixel offset
module row_addr_gen #(
    parameter int IMG_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  step,
    input  logic                  next_row,
    output logic [ADDR_WIDTH-1:0] offset,
    output logic                  last_col
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    logic [COL_W-1:0] col;
    logic [ADDR_WIDTH-1:0] row_base;
    assign last_col = col == COL_W'(IMG_WIDTH - 1);
    assign offset = row_base + ADDR_WIDTH'(col);
    // row_base advances by one row width instead of multiplying row*IMG_WIDTH
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            col <= '0;
            row_base <= '0;
        end else begin
            if (step) col <= last_col ? '0 : col + 1'b1;
            if (next_row) row_base <= row_base + ADDR_WIDTH'(IMG_WIDTH);
        end
    end
endmodule

// File: rtl/edge_pipeline_sequencer.sv
// edge_pipeline_sequencer: walks the image row by row (read, convolve, write back),
// then runs the NMS and thresholding passes, each behind a start/done handshake.
module edge_pipeline_sequencer
    import edge_pipeline_pkg::*;
#(
    parameter int IMG_WIDTH = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int SRC_BASE = DEF_SRC_BASE,
    parameter int DST_BASE = DEF_DST_BASE
) (
    input logic clk,
    input logic reset_n,
    edge_pipeline_sequencer_if.master bus
);
    localparam int ROW_W = row_w(IMG_HEIGHT);
    state_t state, state_d;
    logic [ROW_W-1:0] row;
    logic [ADDR_WIDTH-1:0] offset;
    logic pend, last_col, last_row, rd, wr, row_adv;
    assign last_row = row == ROW_W'(IMG_HEIGHT - 1);
    assign rd = bus.enable && state == READ_ROW;
    assign wr = bus.enable && state == WRITE_ROW;
    assign row_adv = wr && last_col && !last_row;
    row_addr_gen #(.IMG_WIDTH(IMG_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_addr (
        .clk(clk),
        .reset_n(reset_n),
        .clear(state_d == IDLE),
        .step(rd || wr),
        .next_row(row_adv),
        .offset(offset),
        .last_col(last_col)
    );
    // pend marks a freshly entered state whose start pulse has not yet gone out on an enabled cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            row <= '0;
            pend <= 1'b0;
        end else begin
            state <= state_d;
            row <= state_d == IDLE ? '0 : row_adv ? row + 1'b1 : row;
            pend <= state_d != state || (pend && !bus.enable);
        end
    end
    always_comb begin
        state_d = state;
        if (bus.abort) state_d = IDLE;
        else if (bus.enable)
            case (state)
                IDLE:      state_d = bus.start ? READ_ROW : IDLE;
                READ_ROW:  state_d = last_col ? CONV_WAIT : READ_ROW;
                CONV_WAIT: state_d = bus.conv_done ? WRITE_ROW : CONV_WAIT;
                WRITE_ROW: state_d = !last_col ? WRITE_ROW : last_row ? NSM_WAIT : READ_ROW;
                NSM_WAIT:  state_d = bus.nsm_done ? THR_WAIT : NSM_WAIT;
                THR_WAIT:  state_d = bus.thr_done ? DONE : THR_WAIT;
                DONE:      state_d = IDLE;
                default:   state_d = IDLE;
            endcase
    end
    always_comb begin
        bus.transfer_data = rd;
        bus.write_bram4 = wr;
        bus.start_convolution = bus.enable && pend && state == CONV_WAIT;
        bus.start_nsm = bus.enable && pend && state == NSM_WAIT;
        bus.start_thresholding = bus.enable && pend && state == THR_WAIT;
        bus.frame_done = bus.enable && state == DONE;
        bus.busy = state != IDLE;
        bus.row_idx = row;
        bus.bram_addr = rd ? ADDR_WIDTH'(SRC_BASE) + offset : wr ? ADDR_WIDTH'(DST_BASE) + offset : '0;
    end
endmodule

// File: tb/tb_edge_pipeline_sequencer.sv
// tb_edge_pipeline_sequencer: event-queue reference model of one frame, compared cycle by cycle
// against the sequencer under directed and randomized enable/done/start stimulus.
module tb_edge_pipeline_sequencer;
    localparam int W = 4, H = 3, AW = 12, SRC = 0, DST = 2048;
    localparam int K_RD = 0, K_CONV = 1, K_WR = 2, K_NSM = 3, K_THR = 4, K_FD = 5;
    typedef struct {
        int kind;
        int addr;
        int row;
        int col;
    } ev_t;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    edge_pipeline_sequencer_if #(.ADDR_WIDTH(AW), .ROW_W(2)) bus ();
    edge_pipeline_sequencer_if #(.ADDR_WIDTH(AW), .ROW_W(1)) bus2 ();
    edge_pipeline_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW), .SRC_BASE(SRC), .DST_BASE(DST)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    edge_pipeline_sequencer #(.IMG_WIDTH(2), .IMG_HEIGHT(1), .ADDR_WIDTH(AW), .SRC_BASE(SRC), .DST_BASE(DST)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2)
    );
    function automatic ev_t mk(input int kind, input int addr, input int row, input int col);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.row = row;
        e.col = col;
        return e;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // One frame: the expected event list is built from the row/column rules; done responses come
    // two cycles after each observed start pulse and are held until the next event shows up.
    task automatic run_frame(input bit rnd, input int abort_row, input int rst_row, input int freeze_row,
                             output int fd_cycle);
        ev_t q[$];
        ev_t e, last;
        int conv_cnt = -1, nsm_cnt = -1, thr_cnt = -1, freeze = 0, post = -1, n, kind;
        bit busy_exp = 1'b1, frozen = 1'b0, stray_ok, fin = 1'b0;
        fd_cycle = -1;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) q.push_back(mk(K_RD, SRC + r * W + c, r, c));
            q.push_back(mk(K_CONV, 0, r, 0));
            for (int c = 0; c < W; c++) q.push_back(mk(K_WR, DST + r * W + c, r, c));
        end
        q.push_back(mk(K_NSM, 0, H - 1, 0));
        q.push_back(mk(K_THR, 0, H - 1, 0));
        q.push_back(mk(K_FD, 0, H - 1, 0));
        last = mk(-1, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.enable = 1'b1;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.conv_done = 1'b0;
        bus.nsm_done = 1'b0;
        bus.thr_done = 1'b0;
        #2;
        chk("pre_start_busy", bus.busy, 0);
        for (int cyc = 1; cyc < 1000 && !fin; cyc++) begin
            @(negedge clk);
            if (conv_cnt > 0) conv_cnt--;
            if (nsm_cnt > 0) nsm_cnt--;
            if (thr_cnt > 0) thr_cnt--;
            stray_ok = busy_exp && last.kind == K_RD && last.col != W - 1;
            if (freeze_row >= 0 && !frozen && last.kind == K_RD && last.row == freeze_row && last.col == 1) begin
                frozen = 1'b1;
                freeze = 5;
            end
            bus.enable = freeze > 0 ? 1'b0 : rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (freeze > 0) freeze--;
            bus.start = busy_exp && rnd && $urandom_range(0, 1) == 1;
            bus.conv_done = conv_cnt == 0 || (rnd && stray_ok && $urandom_range(0, 1) == 1);
            bus.nsm_done = nsm_cnt == 0 || (rnd && (stray_ok || last.kind == K_CONV) && $urandom_range(0, 1) == 1);
            bus.thr_done = thr_cnt == 0 || (rnd && stray_ok && $urandom_range(0, 1) == 1);
            bus.abort = post < 0 && abort_row >= 0 && last.kind == K_CONV && last.row == abort_row;
            reset_n = !(post < 0 && rst_row >= 0 && last.kind == K_WR && last.row == rst_row && last.col == 1);
            #2;
            n = int'(bus.transfer_data) + int'(bus.write_bram4) + int'(bus.start_convolution) +
                int'(bus.start_nsm) + int'(bus.start_thresholding) + int'(bus.frame_done);
            chk("single_event", n > 1, 0);
            chk("busy", bus.busy, busy_exp);
            if (!bus.enable) chk("frozen_quiet", n, 0);
            if (n == 0) begin
                chk("idle_addr", bus.bram_addr, 0);
                if (!busy_exp) chk("idle_row", bus.row_idx, 0);
            end else begin
                kind = bus.transfer_data ? K_RD : bus.write_bram4 ? K_WR : bus.start_convolution ? K_CONV :
                       bus.start_nsm ? K_NSM : bus.start_thresholding ? K_THR : K_FD;
                chk("event_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("event_kind", kind, e.kind);
                    chk("event_addr", bus.bram_addr, e.addr);
                    chk("event_row", bus.row_idx, e.row);
                    last = e;
                    if (e.kind == K_CONV) conv_cnt = 2;
                    if (e.kind == K_WR) conv_cnt = -1;
                    if (e.kind == K_NSM) nsm_cnt = 2;
                    if (e.kind == K_THR) begin
                        nsm_cnt = -1;
                        thr_cnt = 2;
                    end
                    if (e.kind == K_FD) begin
                        thr_cnt = -1;
                        fd_cycle = cyc;
                        busy_exp = 1'b0;
                        post = 2;
                    end
                end
            end
            if (bus.abort || !reset_n) begin
                q.delete();
                busy_exp = 1'b0;
                post = 3;
                conv_cnt = -1;
                nsm_cnt = -1;
                thr_cnt = -1;
                last = mk(-1, 0, 0, 0);
            end
            if (post == 0) fin = 1'b1;
            else if (post > 0) post--;
        end
        chk("frame_terminated", fin, 1);
        if (abort_row < 0 && rst_row < 0) chk("events_drained", q.size(), 0);
        reset_n = 1'b1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        bus.conv_done = 1'b0;
        bus.nsm_done = 1'b0;
        bus.thr_done = 1'b0;
    endtask
    initial begin
        int fd, fd_count;
        bus.enable = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.conv_done = 1'b0;
        bus.nsm_done = 1'b0;
        bus.thr_done = 1'b0;
        bus2.enable = 1'b1;
        bus2.start = 1'b0;
        bus2.abort = 1'b0;
        bus2.conv_done = 1'b1;
        bus2.nsm_done = 1'b1;
        bus2.thr_done = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_addr", bus.bram_addr, 0);
        chk("rst_transfer", bus.transfer_data, 0);
        chk("rst_write", bus.write_bram4, 0);
        chk("rst_start_conv", bus.start_convolution, 0);
        chk("rst_start_nsm", bus.start_nsm, 0);
        chk("rst_start_thr", bus.start_thresholding, 0);
        chk("rst_row", bus.row_idx, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        run_frame(1'b0, -1, -1, -1, fd);
        chk("frame_latency", fd, 40);
        run_frame(1'b1, -1, -1, 1, fd);
        run_frame(1'b0, 1, -1, -1, fd);
        chk("abort_no_frame_done", fd, -1);
        run_frame(1'b0, -1, -1, -1, fd);
        chk("restart_latency", fd, 40);
        run_frame(1'b0, -1, 0, -1, fd);
        chk("reset_no_frame_done", fd, -1);
        run_frame(1'b1, -1, -1, 0, fd);
        run_frame(1'b1, -1, -1, -1, fd);
        @(negedge clk);
        bus2.start = 1'b1;
        fd = -1;
        fd_count = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            bus2.start = 1'b0;
            #2;
            if (bus2.frame_done) begin
                fd_count++;
                if (fd < 0) fd = cyc;
            end
        end
        chk("h1w2_latency", fd, 8);
        chk("h1w2_frame_done_count", fd_count, 1);
        chk("h1w2_idle_busy", bus2.busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
